// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of {addr, data, be} write entries drained to
// data memory by a two-state FSM, with a combinational word-address lookup
// for loads.
// Optional feature macro: STORE_BUFFER_FWD_EN enables load forwarding from
// the youngest matching full-word entry. With it undefined, ld_hit and
// ld_data stay 0 and loads that conflict must wait for the drain.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    input  logic [AW-1:0]          st_addr,
    input  logic [31:0]            st_data,
    input  logic [3:0]             st_be,
    output logic                   st_ready,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_conflict,
    output logic                   ld_hit,
    output logic [31:0]            ld_data,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_be,
    input  logic                   mem_ack,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [AW-1:0] e_addr [DEPTH];
    logic [31:0]   e_data [DEPTH];
    logic [3:0]    e_be   [DEPTH];

    logic [PW-1:0] head, tail, head_nx;
    state_t        state, state_d;
    logic          push, pop;
    logic          req_d;
    logic [AW-1:0] addr_d;
    logic [31:0]   wdata_d;
    logic [3:0]    be_d;

    // Only the word address takes part in the lookup.
    wire unused_ld_lsb = ^ld_addr[1:0];

    // A handshake with st_be==0 is accepted but leaves no entry behind.
    assign st_ready = (count < FULL);
    assign push     = st_valid && st_ready && (st_be != 4'h0);
    assign pop      = (state == BUSY) && mem_ack;
    assign head_nx  = head + PW'(1);

    // Entry storage; validity is implied by head/count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= st_addr;
            e_data[tail] <= st_data;
            e_be[tail]   <= st_be;
        end
    end

    // Pointers and occupancy; power-of-two depth makes wrap free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head_nx;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Drain FSM next state and next memory request. The head stays counted
    // until its ack edge, so on ack the next entry is at head+1, or is the
    // store being pushed in the same cycle when only the head remained.
    always_comb begin
        state_d = state;
        req_d   = mem_req;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        be_d    = mem_be;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    addr_d  = e_addr[head];
                    wdata_d = e_data[head];
                    be_d    = e_be[head];
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (count > CW'(1)) begin
                        addr_d  = e_addr[head_nx];
                        wdata_d = e_data[head_nx];
                        be_d    = e_be[head_nx];
                    end else if (push) begin
                        addr_d  = st_addr;
                        wdata_d = st_data;
                        be_d    = st_be;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered write request to data memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            mem_req   <= req_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_be    <= be_d;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [31:0] y_data;
    logic [3:0]  y_be;
`endif

    // Load lookup, walking oldest to youngest so the last match is youngest.
    always_comb begin
        logic [PW-1:0] idx;
        idx         = '0;
        ld_conflict = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        y_data = '0;
        y_be   = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (e_addr[idx][AW-1:2] == ld_addr[AW-1:2])) begin
                ld_conflict = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                y_data = e_data[idx];
                y_be   = e_be[idx];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    // Forward only when the youngest match covers the whole word.
    assign ld_hit  = ld_conflict && (y_be == 4'hF);
    assign ld_data = ld_hit ? y_data : 32'h0;
`else
    assign ld_hit  = 1'b0;
    assign ld_data = 32'h0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4, AW=32): directed table of
// fill/lookup vectors plus hand-written drain, back-pressure, forwarding and
// reset-mid-drain sequences. Writes are collected by a handshake monitor.
module tb_store_buffer;

    logic        clk, rst_n;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    logic [3:0]  st_be;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_conflict, ld_hit;
    logic [31:0] ld_data;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [2:0]  count;

    store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Completed memory writes, {addr, data, be}.
    logic [67:0] got[$];
    logic [67:0] exp_q[$];

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) got.push_back({mem_addr, mem_wdata, mem_be});
    end

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else passed++;
    endtask

    task automatic chk_writes(input string nm);
        chk({nm, " nwrites"}, 68'(got.size()), 68'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s write%0d", nm, i), got[i], exp_q[i]);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] la;
        logic        e_ready;
        logic [2:0]  e_count;
        logic        e_req;
        logic [31:0] e_maddr;
        logic [31:0] e_mdata;
        logic        e_conf;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // Fill with mem_ack low: a be==0 store is discarded, four fit, fifth refused.
        tbl[0] = '{1'b1, 32'h500, 32'hFFFF_FFFF, 4'h0, 32'h500, 1'b1, 3'd0, 1'b0, 32'h0,   32'h0,         1'b0};
        tbl[1] = '{1'b1, 32'h400, 32'hA1A1_0001, 4'hF, 32'h500, 1'b1, 3'd1, 1'b0, 32'h0,   32'h0,         1'b0};
        tbl[2] = '{1'b1, 32'h404, 32'hA1A1_0002, 4'hF, 32'h402, 1'b1, 3'd2, 1'b1, 32'h400, 32'hA1A1_0001, 1'b1};
        tbl[3] = '{1'b1, 32'h408, 32'hA1A1_0003, 4'hF, 32'h404, 1'b1, 3'd3, 1'b1, 32'h400, 32'hA1A1_0001, 1'b1};
        tbl[4] = '{1'b1, 32'h40C, 32'hA1A1_0004, 4'hF, 32'h500, 1'b0, 3'd4, 1'b1, 32'h400, 32'hA1A1_0001, 1'b0};
        tbl[5] = '{1'b1, 32'h410, 32'hA1A1_0005, 4'hF, 32'h410, 1'b0, 3'd4, 1'b1, 32'h400, 32'hA1A1_0001, 1'b0};
        tbl[6] = '{1'b0, 32'h0,   32'h0,         4'h0, 32'h40F, 1'b0, 3'd4, 1'b1, 32'h400, 32'hA1A1_0001, 1'b1};

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_addr = 32'h0; mem_ack = 1'b0;

        // Reset state.
        #3;
        chk("rst st_ready", 68'(st_ready), 68'(1));
        chk("rst count", 68'(count), 68'(0));
        chk("rst mem_req", 68'(mem_req), 68'(0));
        chk("rst mem_bus", {mem_addr, mem_wdata, mem_be}, 68'(0));
        chk("rst ld", {ld_conflict, ld_hit, ld_data}, 68'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single store, ack tied high.
        mem_ack = 1'b1;
        st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEAD_BEEF; st_be = 4'hF;
        @(negedge clk);
        st_valid = 1'b0;
        chk("single req N", 68'(mem_req), 68'(0));
        chk("single count N", 68'(count), 68'(1));
        @(negedge clk);
        chk("single req N+1", 68'(mem_req), 68'(1));
        chk("single bus N+1", {mem_addr, mem_wdata, mem_be}, {32'h100, 32'hDEAD_BEEF, 4'hF});
        chk("single count N+1", 68'(count), 68'(1));
        @(negedge clk);
        chk("single req N+2", 68'(mem_req), 68'(0));
        chk("single count N+2", 68'(count), 68'(0));
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_q.push_back({32'h100, 32'hDEAD_BEEF, 4'hF});
        chk_writes("single");
        got.delete(); exp_q.delete();

        // Table: fill to full, back-pressure, lookups.
        mem_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            st_valid = tbl[i].v; st_addr = tbl[i].a; st_data = tbl[i].d; st_be = tbl[i].be;
            ld_addr = tbl[i].la;
            @(negedge clk);
            chk($sformatf("tbl%0d st_ready", i), 68'(st_ready), 68'(tbl[i].e_ready));
            chk($sformatf("tbl%0d count", i), 68'(count), 68'(tbl[i].e_count));
            chk($sformatf("tbl%0d mem_req", i), 68'(mem_req), 68'(tbl[i].e_req));
            chk($sformatf("tbl%0d conflict", i), 68'(ld_conflict), 68'(tbl[i].e_conf));
            if (tbl[i].e_req)
                chk($sformatf("tbl%0d mem_bus", i), {mem_addr, mem_wdata}, 68'({tbl[i].e_maddr, tbl[i].e_mdata}));
        end
        st_valid = 1'b0;

        // Drain the full buffer at one write per cycle.
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back({32'h400 + 32'(4*i), 32'hA1A1_0001 + 32'(i), 4'hF});
        for (int g = 0; g < 20 && count != 0; g++) @(negedge clk);
        @(negedge clk);
        chk("drain count", 68'(count), 68'(0));
        chk("drain mem_req", 68'(mem_req), 68'(0));
        chk_writes("drain");
        got.delete(); exp_q.delete();

        // Slow acks (3 idle cycles per write) with pushes continuing; wraps pointers.
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back({32'h1000 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 4'hF});
        fork
            begin
                int n = 0;
                for (int g = 0; g < 400 && n < 8; g++) begin
                    if (st_ready) begin
                        st_valid = 1'b1; st_addr = 32'h1000 + 32'(4*n);
                        st_data = 32'hC0DE_0000 + 32'(n); st_be = 4'hF;
                        n++;
                    end else st_valid = 1'b0;
                    @(negedge clk);
                end
                st_valid = 1'b0;
            end
            begin
                int w = 0;
                for (int g = 0; g < 600 && got.size() < 8; g++) begin
                    @(negedge clk);
                    if (mem_req) begin
                        if (w == 3) begin mem_ack = 1'b1; w = 0; end
                        else begin mem_ack = 1'b0; w++; end
                    end else begin
                        mem_ack = 1'b0; w = 0;
                    end
                end
                mem_ack = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        chk("slow count", 68'(count), 68'(0));
        chk_writes("slow");
        got.delete(); exp_q.delete();

        // Lookup and forwarding, then reset while BUSY with 3 entries.
        mem_ack = 1'b0;
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h1111_1111; st_be = 4'hF;
        @(negedge clk);
        st_data = 32'h2222_2222;
        @(negedge clk);
        st_addr = 32'h300; st_data = 32'h3333_3333; st_be = 4'h3;
        @(negedge clk);
        st_valid = 1'b0;
        chk("fwd count", 68'(count), 68'(3));
        chk("fwd mem_req", 68'(mem_req), 68'(1));
        chk("fwd mem_bus", {mem_addr, mem_wdata}, 68'({32'h200, 32'h1111_1111}));
        ld_addr = 32'h203; #1;
        chk("fwd 0x203 conflict", 68'(ld_conflict), 68'(1));
`ifdef STORE_BUFFER_FWD_EN
        chk("fwd 0x203 hit", 68'(ld_hit), 68'(1));
        chk("fwd 0x203 data", 68'(ld_data), 68'(32'h2222_2222));
`else
        chk("fwd 0x203 hit", 68'(ld_hit), 68'(0));
        chk("fwd 0x203 data", 68'(ld_data), 68'(0));
`endif
        ld_addr = 32'h300; #1;
        chk("part 0x300 conflict", 68'(ld_conflict), 68'(1));
        chk("part 0x300 hit", {ld_hit, ld_data}, 68'(0));
        ld_addr = 32'h304; #1;
        chk("miss 0x304 conflict", 68'(ld_conflict), 68'(0));
        ld_addr = 32'h200;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst mem_req", 68'(mem_req), 68'(0));
        chk("midrst count", 68'(count), 68'(0));
        chk("midrst ready", 68'(st_ready), 68'(1));
        chk("midrst conflict", 68'(ld_conflict), 68'(0));
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst mem_req", 68'(mem_req), 68'(0));
        chk_writes("postrst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of store entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32: byte-address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port st_valid, input, 1: store request from the register-to-cache stage.
REQ-006 SHALL have port st_addr, input, AW: store byte address.
REQ-007 SHALL have port st_data, input, 32: store data word.
REQ-008 SHALL have port st_be, input, 4: byte enables, bit i selects byte lane [8i+7:8i].
REQ-009 SHALL have port st_ready, output, 1: store accepted when st_valid && st_ready.
REQ-010 SHALL have port ld_addr, input, AW: load address for conflict lookup.
REQ-011 SHALL have port ld_conflict, output, 1: some buffered entry matches ld_addr word.
REQ-012 SHALL have port ld_hit, output, 1: load fully satisfied from buffer.
REQ-013 SHALL have port ld_data, output, 32: forwarded load data.
REQ-014 SHALL have ports mem_req (output, 1), mem_addr (output, AW), mem_wdata (output, 32) and mem_be (output, 4): registered write request to data memory.
REQ-015 SHALL have port mem_ack, input, 1: memory accepted the current write.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1: occupied entries.

Function
REQ-017 SHALL hold entries {addr, data, be} in a circular FIFO, with head/tail pointers wrapping modulo DEPTH.
REQ-018 SHALL drive st_ready = (count < DEPTH), with no same-cycle bypass when full.
REQ-019 SHALL push at the edge where st_valid && st_ready; a push with st_be==0 SHALL be accepted and discarded.
REQ-020 SHALL run drain FSM IDLE/BUSY; IDLE with count>0 -> BUSY, loading mem_addr/mem_wdata/mem_be from head and setting mem_req=1.
REQ-021 SHALL in BUSY hold mem_* stable until mem_ack; on mem_ack pop head; if entries remain, reload from new head, keep mem_req=1 and stay BUSY; else -> IDLE, mem_req=0.
REQ-022 SHALL ignore mem_ack in IDLE.
REQ-023 SHALL give latency: store accepted at edge N with buffer empty -> mem_req high after edge N+1; back-to-back drains give 1 write per acked cycle.
REQ-024 SHALL keep the head entry counted and visible to lookup until its ack edge.
REQ-025 SHALL on simultaneous push and pop leave count unchanged, and SHALL accept a push when full at the edge of a pop only if st_ready was high in that cycle (i.e. never).
REQ-026 SHALL compare ld_addr[AW-1:2] combinationally against all valid entries; any match -> ld_conflict=1.

Reset
REQ-027 SHALL on rst_n low immediately clear pointers, count=0, FSM=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0.
REQ-028 SHALL drop pending stores on reset mid-drain, even with mem_req high, without awaiting mem_ack.
REQ-029 SHALL have combinational outputs after reset: st_ready=1, ld_conflict=0, ld_hit=0, ld_data=0.

Configuration
REQ-030 SHALL, with STORE_BUFFER_FWD_EN defined, set ld_hit=1 and ld_data=youngest matching entry's data iff that entry has be==4'hF; otherwise ld_hit=0 and ld_data=0.
REQ-031 SHALL, without STORE_BUFFER_FWD_EN, tie ld_hit=0 and ld_data=0; ld_conflict is unaffected, and the pipeline stalls until drained.

Verification
REQ-032 SHALL cover reset then store A=0x100 D=0xDEADBEEF be=F, mem_ack tied 1 -> mem_req high the cycle after next, single write, count returns to 0.
REQ-033 SHALL cover DEPTH=4, mem_ack=0, five consecutive stores -> four accepted, st_ready=0 on fifth, count=4, mem_* shows first store.
REQ-034 SHALL cover mem_ack after 3 idle cycles per write, with pushes continuing -> writes in order, no loss or duplicate, pointers wrap past index 3.
REQ-035 SHALL cover stores 0x200/0x11111111 then 0x200/0x22222222, load 0x203 -> ld_conflict=1; with FWD_EN ld_hit=1, ld_data=0x22222222; without, ld_hit=0.
REQ-036 SHALL cover store 0x300 be=0011, load 0x300 -> ld_conflict=1, ld_hit=0.
REQ-037 SHALL cover rst_n pulled low while BUSY with 3 entries -> mem_req=0 immediately, count=0, and after release no further writes.
